param_bus_memory: RTL and testbench

PARAM_BUS_MEMORY -- requirements
Module: param_bus_memory

---
 rtl/param_bus_memory_if.sv | 26 ++
 rtl/param_bus_memory.sv | 97 +++++++++
 tb/tb_param_bus_memory.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_bus_memory_if.sv
// Request/response bus between a requester (master) and the parameterised word memory (slave).
interface param_bus_memory_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/param_bus_memory.sv
// Word memory with byte enables behind a valid/ready bus; optionally zeroed after reset.
// Responses arrive one cycle after acceptance and are held stable under backpressure.
module param_bus_memory #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  param_bus_memory_if.slave bus,
  output logic              init_done
);
  // state | meaning
  // CLEAR | reset / zeroing the array, bus not ready
  // IDLE  | serving requests, no stalled response
  // HOLD  | response presented but not yet taken by the consumer
  typedef enum logic [1:0] {CLEAR, IDLE, HOLD} state_t;

  localparam int                BE_W    = DATA_W / 8;
  localparam int                LAST_I  = DEPTH - 1;
  localparam logic [ADDR_W:0]   DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST    = LAST_I[ADDR_W-1:0];

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic                in_range;
  logic                clr_we;
  logic                clr_last;
  logic                req_ready;
  logic                rsp_valid;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_rdata;

  assign in_range = {1'b0, bus.req_addr} < DEPTH_L;
  assign clr_last = (clr_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:      if (!INIT_CLEAR || clr_last) state_nxt = IDLE;
      IDLE, HOLD: state_nxt = (rsp_valid && !bus.rsp_ready) ? HOLD : IDLE;
      default:    state_nxt = CLEAR;
    endcase
  end

  // Outputs are also gated by rst so nothing is offered in the cycle reset is raised.
  always_comb begin
    init_done = (state != CLEAR) && !rst;
    clr_we    = (state == CLEAR) && INIT_CLEAR && !rst;
    req_ready = init_done && (!rsp_valid || bus.rsp_ready);
    accept    = bus.req_valid && req_ready;
  end

  always_ff @(posedge clk) begin
    if (rst)                       clr_cnt <= '0;
    else if (clr_we && !clr_last)  clr_cnt <= clr_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= !in_range;
      rsp_rdata <= (!bus.req_wr && in_range) ? mem[bus.req_addr] : '0;
    end else if (bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Array has no reset of its own; zeroing is done word by word from CLEAR.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (accept && bus.req_wr && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.req_be[b]) mem[bus.req_addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
endmodule

// File: tb/tb_param_bus_memory.sv
// Bench for param_bus_memory: default instance plus a DEPTH=12 instance for out-of-range cases.
module tb_param_bus_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done_a, done_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] model [16];
  logic [31:0] rd;
  logic        er, vl;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vt [9];

  param_bus_memory_if #(.DATA_W(32), .ADDR_W(4)) ba ();
  param_bus_memory_if #(.DATA_W(32), .ADDR_W(4)) bb ();

  param_bus_memory #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .INIT_CLEAR(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(ba), .init_done(done_a));
  param_bus_memory #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .INIT_CLEAR(1'b1)) u_dut12 (
    .clk(clk), .rst(rst), .bus(bb), .init_done(done_b));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_wr(int a, logic [31:0] d, logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    model[a] = (model[a] & ~mask) | (d & mask);
  endfunction

  task automatic drive(bit b, bit v, bit wr, logic [3:0] a, logic [31:0] d, logic [3:0] be);
    if (b) begin
      bb.req_valid = v; bb.req_wr = wr; bb.req_addr = a; bb.req_wdata = d; bb.req_be = be;
    end else begin
      ba.req_valid = v; ba.req_wr = wr; ba.req_addr = a; ba.req_wdata = d; ba.req_be = be;
    end
  endtask

  task automatic set_rr(bit b, bit r);
    if (b) bb.rsp_ready = r;
    else   ba.rsp_ready = r;
  endtask

  function automatic logic get_rdy(bit b);   return b ? bb.req_ready : ba.req_ready; endfunction
  function automatic logic get_rv(bit b);    return b ? bb.rsp_valid : ba.rsp_valid; endfunction
  function automatic logic get_err(bit b);   return b ? bb.rsp_err   : ba.rsp_err;   endfunction
  function automatic logic [31:0] get_rd(bit b); return b ? bb.rsp_rdata : ba.rsp_rdata; endfunction

  // One complete transaction; the response is held for 'stall' extra cycles before being taken.
  task automatic xact(bit b, bit wr, logic [3:0] a, logic [31:0] d, logic [3:0] be, int stall,
                      output logic [31:0] rdo, output logic erro, output logic vlo);
    int t;
    @(negedge clk);
    drive(b, 1'b1, wr, a, d, be);
    set_rr(b, stall == 0);
    t = 0;
    while (!get_rdy(b) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!get_rdy(b)) begin
      n_fail++;
      $display("FAIL accept_timeout: req_ready still 0 after %0d cycles, expected 1", t);
      drive(b, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      set_rr(b, 1'b1);
      rdo = 32'hxxxxxxxx; erro = 1'bx; vlo = 1'b0;
      return;
    end
    @(posedge clk); #1;
    drive(b, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    repeat (stall + 1) @(negedge clk);
    rdo = get_rd(b); erro = get_err(b); vlo = get_rv(b);
    set_rr(b, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, ta, tb;
    bit wr;
    logic [3:0] a, be;
    logic [31:0] d, exp;

    vt[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    vt[1] = '{1'b0, 4'd3,  32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b1, 4'd3,  32'h11223344, 4'h5, 32'h00000000, 1'b0};
    vt[3] = '{1'b0, 4'd3,  32'h00000000, 4'h0, 32'hDE22BE44, 1'b0};
    vt[4] = '{1'b1, 4'd7,  32'hCAFEF00D, 4'h0, 32'h00000000, 1'b0};
    vt[5] = '{1'b0, 4'd7,  32'h00000000, 4'h0, 32'h00000000, 1'b0};
    vt[6] = '{1'b1, 4'd0,  32'hA5A5A5A5, 4'hA, 32'h00000000, 1'b0};
    vt[7] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 32'hA500A500, 1'b0};
    vt[8] = '{1'b0, 4'd15, 32'h00000000, 4'h0, 32'h00000000, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_rr(1'b0, 1'b1);
    set_rr(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", ba.rsp_valid, 1'b0);
    check("rst_req_ready", ba.req_ready, 1'b0);
    check("rst_init_done", done_a, 1'b0);
    check("rst_rsp_rdata", ba.rsp_rdata, 32'h0);
    check("rst_rsp_err", ba.rsp_err, 1'b0);

    // Clear length for both depths
    rst = 1'b0;
    t = 0; ta = -1; tb = -1;
    while ((ta < 0 || tb < 0) && t < 40) begin
      @(negedge clk);
      t++;
      if (ta < 0 && done_a) ta = t;
      if (tb < 0 && done_b) tb = t;
    end
    check("init_cycles_d16", ta, 16);
    check("init_cycles_d12", tb, 12);

    for (int i = 0; i < 16; i++) begin
      xact(1'b0, 1'b0, 4'(i), 32'h0, 4'h0, 0, rd, er, vl);
      check("cleared_word", rd, 32'h0);
    end

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      xact(1'b0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, i % 3, rd, er, vl);
      check("vec_valid", vl, 1'b1);
      check("vec_rdata", rd, vt[i].exp_rd);
      check("vec_err", er, vt[i].exp_err);
      if (vt[i].wr) model_wr(vt[i].addr, vt[i].wdata, vt[i].be);
    end

    // Backpressure: response held 3 cycles, then handshake and new acceptance together
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    set_rr(1'b0, 1'b0);
    check("hold_ready_before", ba.req_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'd9, 32'h0BADF00D, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", ba.rsp_valid, 1'b1);
      check("hold_rdata", ba.rsp_rdata, 32'hDE22BE44);
      check("hold_err", ba.rsp_err, 1'b0);
      check("hold_req_ready", ba.req_ready, 1'b0);
    end
    set_rr(1'b0, 1'b1);
    #1 check("release_req_ready", ba.req_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    model_wr(9, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    check("b2b_wr_valid", ba.rsp_valid, 1'b1);
    check("b2b_wr_rdata", ba.rsp_rdata, 32'h0);
    @(negedge clk);
    check("valid_drops", ba.rsp_valid, 1'b0);

    // Write then read of the same word on consecutive cycles
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 4'd5, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    @(negedge clk);
    check("raw_wr_rsp", ba.rsp_rdata, 32'h0);
    check("raw_ready", ba.req_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("raw_rd_valid", ba.rsp_valid, 1'b1);
    check("raw_rd_rdata", ba.rsp_rdata, 32'h12345678);
    model_wr(5, 32'h12345678, 4'hF);
    @(posedge clk); #1;

    // Out-of-range on DEPTH=12
    xact(1'b1, 1'b1, 4'd13, 32'hFFFFFFFF, 4'hF, 0, rd, er, vl);
    check("oor_wr_err", er, 1'b1);
    check("oor_wr_rdata", rd, 32'h0);
    xact(1'b1, 1'b0, 4'd13, 32'h0, 4'h0, 1, rd, er, vl);
    check("oor_rd_err", er, 1'b1);
    check("oor_rd_rdata", rd, 32'h0);
    xact(1'b1, 1'b0, 4'd12, 32'h0, 4'h0, 0, rd, er, vl);
    check("oor_edge_err", er, 1'b1);
    for (int i = 0; i < 12; i++) begin
      xact(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 0, rd, er, vl);
      check("d12_word", rd, 32'h0);
      check("d12_err", er, 1'b0);
    end

    // Randomised traffic against the array model
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      exp = wr ? 32'h0 : model[a];
      xact(1'b0, wr, a, d, be, int'($urandom_range(0, 2)), rd, er, vl);
      check("rnd_valid", vl, 1'b1);
      check("rnd_rdata", rd, exp);
      check("rnd_err", er, 1'b0);
      if (wr) model_wr(a, d, be);
    end

    // Reset with a stalled response pending, then again mid-clear
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    set_rr(1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("pend_valid", ba.rsp_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drop_valid", ba.rsp_valid, 1'b0);
    check("rst_drop_ready", ba.req_ready, 1'b0);
    check("rst_drop_done", done_a, 1'b0);
    check("rst_drop_rdata", ba.rsp_rdata, 32'h0);
    set_rr(1'b0, 1'b1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midclear_done", done_a, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (!done_a && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("reclear_cycles", t, 16);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    xact(1'b0, 1'b0, 4'd9, 32'h0, 4'h0, 0, rd, er, vl);
    check("reclear_w9", rd, model[9]);
    xact(1'b0, 1'b0, 4'd15, 32'h0, 4'h0, 0, rd, er, vl);
    check("reclear_w15", rd, model[15]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
